hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter MAXPEND, default 3, the maximum number of outstanding writes tracked per register (range 1..3).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port of_valid, input, 1, an instruction is present in operand fetch.
REQ-005 SHALL have ports rport1_addr and rport2_addr, input, 4 each, the source register addresses driven to the register file.
REQ-006 SHALL have ports use_rs1 and use_rs2, input, 1 each, the instruction actually reads that port.
REQ-007 SHALL have port rd_addr, input, 4, the destination register; SHALL have port wr_rd, input, 1, the instruction writes rd.
REQ-008 SHALL have ports wb_valid (input, 1) and wb_addr (input, 4), a register-file write retiring this cycle.
REQ-009 SHALL have port flush, input, 1, a branch/ret redirect that discards all in-flight writes.
REQ-010 SHALL have port issue, output, 1, the instruction advances out of operand fetch this cycle.
REQ-011 SHALL have port stall, output, 1, equal to of_valid & ~issue.
REQ-012 SHALL have ports busy_mask (output, 16), bit i set when the count for register i is nonzero, and state (output, 2).
REQ-013 SHALL have port wb_err, output, 1, a sticky retire-underflow error flag.

Function
REQ-014 SHALL hold a pending count pend[i], 2 bits, for each of the 16 registers.
REQ-015 SHALL implement states RUN=2'b00, STALL=2'b01, FLUSH=2'b10; state 2'b11 is unreachable and SHALL recover to RUN on the next edge.
REQ-016 SHALL compute hazard = (use_rs1 & pend[rport1_addr]!=0) | (use_rs2 & pend[rport2_addr]!=0) | (wr_rd & pend[rd_addr]==MAXPEND), using registered pend only; a same-cycle wb_valid is not bypassed.
REQ-017 SHALL drive issue = of_valid & ~hazard & (state!=FLUSH) & ~flush, combinationally in the same cycle.
REQ-018 SHALL increment pend[rd_addr] on an edge where issue & wr_rd, and decrement pend[wb_addr] on an edge where wb_valid; when both target the same register, the count is unchanged.
REQ-019 SHALL ignore wb_valid when pend[wb_addr]==0 and set wb_err, which stays set until reset.
REQ-020 SHALL transition RUN->STALL when stall is asserted, STALL->RUN when issue is asserted or of_valid is low, and any state->FLUSH when flush is asserted; FLUSH->RUN SHALL occur after exactly one cycle unless flush is still high.
REQ-021 SHALL clear every pend[i] on the edge where flush is sampled high, overriding same-cycle increment or decrement; wb_valid SHALL be ignored in FLUSH.
REQ-022 SHALL add no latency between a hazard clearing in pend and issue rising in that same cycle.

Reset
REQ-023 SHALL, while rst_n is low, force pend[i]=0 for all i, state=RUN, wb_err=0, and busy_mask=16'h0000; issue and stall then follow REQ-017 and REQ-011.
REQ-024 SHALL, when reset is asserted mid-stall, release the stall immediately, because pend clears asynchronously.

Configuration
REQ-025 SHALL, with HAZARD_STALL_COUNT_EN defined, add output stall_cnt (16 bits), reset to 0, incremented on each edge where stall=1, and saturating at 16'hFFFF.
REQ-026 SHALL, without HAZARD_STALL_COUNT_EN, omit the stall_cnt port and its logic entirely, with all other behaviour identical.

Verification
REQ-027 Bench SHALL cover: issue wr_rd with rd=2, then next cycle of_valid, use_rs1, rport1_addr=2 -> stall=1, busy_mask=16'h0004; wb_valid, wb_addr=2 -> next cycle issue=1, busy_mask=0.
REQ-028 Bench SHALL cover: pend[5]=1, same edge issue wr_rd rd=5 and wb_valid wb_addr=5 -> pend[5] stays 1, busy_mask bit5=1.
REQ-029 Bench SHALL cover: three issues writing r7 (MAXPEND=3) -> fourth wr_rd rd=7 stalls; one wb to r7 -> fourth issues next cycle.
REQ-030 Bench SHALL cover: busy_mask=16'h00F0 and flush pulse -> next cycle state=FLUSH, issue=0, busy_mask=0; following cycle state=RUN.
REQ-031 Bench SHALL cover: wb_valid, wb_addr=9 with pend[9]=0 -> wb_err=1 persists and pend[9] remains 0; then rst_n low -> wb_err=0 asynchronously.
REQ-032 Bench SHALL cover, with HAZARD_STALL_COUNT_EN: 4 stall cycles -> stall_cnt=4; reset -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Operand-fetch hazard scoreboard: per-register pending-write counts gate issue.
// Optional stall counter output enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_scoreboard #(
    parameter int MAXPEND = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        of_valid,
    input  logic [3:0]  rport1_addr,
    input  logic [3:0]  rport2_addr,
    input  logic        use_rs1,
    input  logic        use_rs2,
    input  logic [3:0]  rd_addr,
    input  logic        wr_rd,
    input  logic        wb_valid,
    input  logic [3:0]  wb_addr,
    input  logic        flush,
    output logic        issue,
    output logic        stall,
    output logic [15:0] busy_mask,
    output logic [1:0]  state,
`ifdef HAZARD_STALL_COUNT_EN
    output logic [15:0] stall_cnt,
`endif
    output logic        wb_err
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10,
        BAD   = 2'b11
    } state_t;

    state_t     st;
    state_t     st_nx;
    logic [1:0] pend [16];
    logic       hazard;
    logic       inc;
    logic       dec;
    logic       under;

    // Hazard from registered counts only; a retiring write is not bypassed.
    always_comb begin
        hazard = (use_rs1 && pend[rport1_addr] != 2'd0)
               | (use_rs2 && pend[rport2_addr] != 2'd0)
               | (wr_rd && pend[rd_addr] == 2'(MAXPEND));
        issue  = of_valid & ~hazard & (st != FLUSH) & ~flush;
        stall  = of_valid & ~issue;
        inc    = issue & wr_rd;
        under  = wb_valid & (st != FLUSH) & (pend[wb_addr] == 2'd0);
        dec    = wb_valid & (st != FLUSH) & (pend[wb_addr] != 2'd0);
        state  = st;
    end

    // Busy bit per register mirrors a nonzero pending count.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < 16; i++) begin
            busy_mask[i] = (pend[i] != 2'd0);
        end
    end

    // Pending counts: flush wipes all, matched inc/dec on one register cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                pend[i] <= 2'd0;
            end
        end else if (flush) begin
            for (int i = 0; i < 16; i++) begin
                pend[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (inc && rd_addr == 4'(i) && !(dec && wb_addr == 4'(i))) begin
                    pend[i] <= pend[i] + 2'd1;
                end else if (dec && wb_addr == 4'(i) && !(inc && rd_addr == 4'(i))) begin
                    pend[i] <= pend[i] - 2'd1;
                end
            end
        end
    end

    // Sticky flag for a retire with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_err <= 1'b0;
        end else if (under) begin
            wb_err <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= RUN;
        end else begin
            st <= st_nx;
        end
    end

    // Next-state: flush dominates, FLUSH lasts one cycle, 2'b11 recovers.
    always_comb begin
        st_nx = RUN;
        if (flush) begin
            st_nx = FLUSH;
        end else begin
            unique case (st)
                RUN:     st_nx = stall ? STALL : RUN;
                STALL:   st_nx = (issue || !of_valid) ? RUN : STALL;
                FLUSH:   st_nx = RUN;
                default: st_nx = RUN;
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
        end else if (stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random stimulus
// against a counting model of outstanding writes.
module tb_hazard_scoreboard;

    localparam int MP = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        of_valid, use_rs1, use_rs2, wr_rd, wb_valid, flush;
    logic [3:0]  rport1_addr, rport2_addr, rd_addr, wb_addr;
    logic        issue, stall, wb_err;
    logic [15:0] busy_mask;
    logic [1:0]  state;
`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] stall_cnt;
`endif

    int vecs = 0;
    int fails = 0;

    int mcnt [16];
    int mst;
    bit merr;
    int mscnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.MAXPEND(MP)) dut (
        .clk(clk), .rst_n(rst_n), .of_valid(of_valid),
        .rport1_addr(rport1_addr), .rport2_addr(rport2_addr),
        .use_rs1(use_rs1), .use_rs2(use_rs2),
        .rd_addr(rd_addr), .wr_rd(wr_rd),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
        .issue(issue), .stall(stall), .busy_mask(busy_mask),
        .state(state),
`ifdef HAZARD_STALL_COUNT_EN
        .stall_cnt(stall_cnt),
`endif
        .wb_err(wb_err)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_issue();
        bit hz;
        hz = (use_rs1 && mcnt[rport1_addr] != 0)
          || (use_rs2 && mcnt[rport2_addr] != 0)
          || (wr_rd && mcnt[rd_addr] == MP);
        return of_valid && !hz && mst != 2 && !flush;
    endfunction

    function automatic logic [15:0] m_busy();
        logic [15:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[i] = (mcnt[i] > 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mcnt[i] = 0;
        mst = 0;
        merr = 0;
        mscnt = 0;
    endtask

    task automatic model_check();
        bit iss;
        iss = m_issue();
        chk("issue", 32'(issue), 32'(iss));
        chk("stall", 32'(stall), 32'(of_valid && !iss));
        chk("busy_mask", 32'(busy_mask), 32'(m_busy()));
        chk("state", 32'(state), 32'(mst));
        chk("wb_err", 32'(wb_err), 32'(merr));
`ifdef HAZARD_STALL_COUNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(mscnt));
`endif
    endtask

    task automatic model_step();
        int  old [16];
        bit  iss, stl;
        iss = m_issue();
        stl = of_valid && !iss;
        for (int i = 0; i < 16; i++) old[i] = mcnt[i];
        if (iss && wr_rd) mcnt[rd_addr]++;
        if (wb_valid && mst != 2) begin
            if (old[wb_addr] == 0) merr = 1;
            else mcnt[wb_addr]--;
        end
        if (flush) for (int i = 0; i < 16; i++) mcnt[i] = 0;
        if (stl && mscnt != 16'hFFFF) mscnt++;
        if (flush) mst = 2;
        else if (mst == 0) mst = stl ? 1 : 0;
        else if (mst == 1) mst = (iss || !of_valid) ? 0 : 1;
        else mst = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic setin(bit ov, bit u1, int a1, bit u2, int a2,
                         bit w, int rd, bit wb, int wa, bit fl);
        of_valid = ov; use_rs1 = u1; rport1_addr = 4'(a1);
        use_rs2 = u2; rport2_addr = 4'(a2);
        wr_rd = w; rd_addr = 4'(rd);
        wb_valid = wb; wb_addr = 4'(wa); flush = fl;
        #1;
        model_check();
    endtask

    task automatic idle();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        model_check();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        idle();
        chk("rst_busy", 32'(busy_mask), 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_err", 32'(wb_err), 32'h0);
        tick();
        rst_n = 1'b1;

        // RAW on r2, retire clears it one cycle later
        setin(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        chk("raw_first_issue", 32'(issue), 32'h1);
        tick();
        setin(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_stall", 32'(stall), 32'h1);
        chk("raw_busy", 32'(busy_mask), 32'h0004);
        tick();
        setin(1, 1, 2, 0, 0, 0, 0, 1, 2, 0);
        chk("raw_no_bypass", 32'(stall), 32'h1);
        tick();
        setin(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_release", 32'(issue), 32'h1);
        chk("raw_busy_clr", 32'(busy_mask), 32'h0);
        tick();

        // Simultaneous issue and retire on r5
        setin(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        tick();
        setin(1, 0, 0, 0, 0, 1, 5, 1, 5, 0);
        chk("r5_issue", 32'(issue), 32'h1);
        tick();
        idle();
        chk("r5_busy", 32'(busy_mask[5]), 32'h1);
        setin(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        tick();
        idle();
        chk("r5_drained", 32'(busy_mask), 32'h0);

        // WAW saturation on r7
        for (int k = 0; k < 3; k++) begin
            setin(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
            tick();
        end
        setin(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        chk("r7_full_stall", 32'(stall), 32'h1);
        tick();
        setin(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        chk("r7_still_stall", 32'(stall), 32'h1);
        tick();
        setin(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        chk("r7_fourth_issue", 32'(issue), 32'h1);
        tick();
        for (int k = 0; k < 3; k++) begin
            setin(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
            tick();
        end

        // Flush wipes r4..r7
        for (int k = 4; k < 8; k++) begin
            setin(1, 0, 0, 0, 0, 1, k, 0, 0, 0);
            tick();
        end
        idle();
        chk("fl_busy_pre", 32'(busy_mask), 32'h00F0);
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        setin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("fl_state", 32'(state), 32'h2);
        chk("fl_issue", 32'(issue), 32'h0);
        chk("fl_busy", 32'(busy_mask), 32'h0);
        tick();
        idle();
        chk("fl_back_run", 32'(state), 32'h0);

        // Underflow retire on r9
        setin(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        tick();
        idle();
        chk("uf_err", 32'(wb_err), 32'h1);
        chk("uf_r9", 32'(busy_mask[9]), 32'h0);
        tick();
        idle();
        chk("uf_sticky", 32'(wb_err), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("uf_async_clr", 32'(wb_err), 32'h0);
        model_reset();
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        // Four stall cycles on r1, then reset releases mid-stall
        setin(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            setin(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STALL_COUNT_EN
        chk("scnt_four", 32'(stall_cnt), 32'h4);
`endif
        setin(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_stall", 32'(stall), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_rel_stall", 32'(stall), 32'h0);
        chk("rst_rel_issue", 32'(issue), 32'h1);
`ifdef HAZARD_STALL_COUNT_EN
        chk("scnt_rst", 32'(stall_cnt), 32'h0);
`endif
        model_reset();
        @(negedge clk);
        idle();
        tick();
        rst_n = 1'b1;

        // Random traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            int a1, a2, rd, wa;
            a1 = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            a2 = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            rd = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            wa = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            setin($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a1,
                  $urandom_range(0, 1) == 1, a2, $urandom_range(0, 1) == 1, rd,
                  $urandom_range(0, 2) == 0, wa, $urandom_range(0, 20) == 0);
            tick();
            if ($urandom_range(0, 499) == 0) begin
                idle();
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
